// File: rtl/pkt_meta_merge.sv
// Pairs queued per-packet meta with queued packet beats in FIFO order and
// applies the meta action (MAC rewrite, passthrough or drop) to the head beat.
module pkt_meta_merge #(
    parameter int PKT_AW  = 9,
    parameter int META_AW = 4,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pkt_valid,
    input  logic [133:0]     i_pkt,
    input  logic             i_meta_valid,
    input  logic [127:0]     i_meta,
    output logic             o_data_valid,
    output logic [133:0]     o_data,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic             o_err_ovf,
    output logic [1:0]       o_dbg_state
);

    // Strobe-only interface: a beat or meta is taken on every cycle its valid
    // is high; there is no ready, so a write into a full FIFO is lost and flagged.

    typedef enum logic [1:0] {IDLE, HEAD, BODY, DROP} state_t;

    state_t state, state_nx;

    logic [133:0]     pkt_mem [0:(1<<PKT_AW)-1];
    logic [PKT_AW:0]  pkt_wp, pkt_rp;
    logic [127:0]     meta_mem [0:(1<<META_AW)-1];
    logic [META_AW:0] meta_wp, meta_rp;

    logic         pkt_empty, pkt_full, pkt_wr, pkt_pop;
    logic         meta_empty, meta_full, meta_wr, meta_pop;
    logic [133:0] pkt_head, emit_data;
    logic [127:0] meta_r;
    logic         is_tail, emit, tail_pkt, tail_drop;

    assign pkt_empty  = (pkt_wp == pkt_rp);
    assign pkt_full   = (pkt_wp[PKT_AW] != pkt_rp[PKT_AW]) &&
                        (pkt_wp[PKT_AW-1:0] == pkt_rp[PKT_AW-1:0]);
    assign meta_empty = (meta_wp == meta_rp);
    assign meta_full  = (meta_wp[META_AW] != meta_rp[META_AW]) &&
                        (meta_wp[META_AW-1:0] == meta_rp[META_AW-1:0]);

    // A pop in the same cycle frees the slot, so a write to a full FIFO is kept.
    assign pkt_wr  = i_pkt_valid  && (!pkt_full  || pkt_pop);
    assign meta_wr = i_meta_valid && (!meta_full || meta_pop);

    assign pkt_head    = pkt_mem[pkt_rp[PKT_AW-1:0]];
    assign is_tail     = pkt_head[133];
    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (pkt_wr)
            pkt_mem[pkt_wp[PKT_AW-1:0]] <= i_pkt;
        if (meta_wr)
            meta_mem[meta_wp[META_AW-1:0]] <= i_meta;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_wp  <= '0;
            pkt_rp  <= '0;
            meta_wp <= '0;
            meta_rp <= '0;
        end else begin
            if (pkt_wr)   pkt_wp  <= pkt_wp  + (PKT_AW+1)'(1);
            if (pkt_pop)  pkt_rp  <= pkt_rp  + (PKT_AW+1)'(1);
            if (meta_wr)  meta_wp <= meta_wp + (META_AW+1)'(1);
            if (meta_pop) meta_rp <= meta_rp + (META_AW+1)'(1);
        end
    end

    always_comb begin
        state_nx  = state;
        pkt_pop   = 1'b0;
        meta_pop  = 1'b0;
        emit      = 1'b0;
        emit_data = pkt_head;
        tail_pkt  = 1'b0;
        tail_drop = 1'b0;
        case (state)
            IDLE: begin
                if (!meta_empty && !pkt_empty) begin
                    meta_pop = 1'b1;
                    state_nx = HEAD;
                end
            end
            HEAD: begin
                // Entry from IDLE guarantees the head beat is already queued.
                pkt_pop = 1'b1;
                if (meta_r[126]) begin
                    tail_drop = is_tail;
                    state_nx  = is_tail ? IDLE : DROP;
                end else begin
                    emit = 1'b1;
                    if (meta_r[127]) begin
                        emit_data[127:80] = meta_r[95:48];
                        emit_data[79:32]  = meta_r[47:0];
                    end
                    tail_pkt = is_tail;
                    state_nx = is_tail ? IDLE : BODY;
                end
            end
            BODY: begin
                if (!pkt_empty) begin
                    pkt_pop  = 1'b1;
                    emit     = 1'b1;
                    tail_pkt = is_tail;
                    if (is_tail) state_nx = IDLE;
                end
            end
            DROP: begin
                if (!pkt_empty) begin
                    pkt_pop   = 1'b1;
                    tail_drop = is_tail;
                    if (is_tail) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            meta_r       <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_pkt_cnt    <= '0;
            o_drop_cnt   <= '0;
            o_err_ovf    <= 1'b0;
        end else begin
            state        <= state_nx;
            o_data_valid <= emit;
            if (meta_pop)  meta_r     <= meta_mem[meta_rp[META_AW-1:0]];
            if (emit)      o_data     <= emit_data;
            if (tail_pkt)  o_pkt_cnt  <= o_pkt_cnt  + CNT_W'(1);
            if (tail_drop) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
            if ((i_pkt_valid && !pkt_wr) || (i_meta_valid && !meta_wr))
                o_err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pkt_meta_merge.sv
// Bench for pkt_meta_merge: table of meta/packet vectors plus hand-written
// sequences for late meta, input gaps, meta overflow and reset mid-packet.
module tb_pkt_meta_merge;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_pkt_valid;
    logic [133:0] i_pkt;
    logic         i_meta_valid;
    logic [127:0] i_meta;
    logic         o_data_valid;
    logic [133:0] o_data;
    logic [31:0]  o_pkt_cnt;
    logic [31:0]  o_drop_cnt;
    logic         o_err_ovf;
    logic [1:0]   o_dbg_state;

    pkt_meta_merge #(.PKT_AW(9), .META_AW(4), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
        .i_meta_valid(i_meta_valid), .i_meta(i_meta),
        .o_data_valid(o_data_valid), .o_data(o_data),
        .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt),
        .o_err_ovf(o_err_ovf), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    logic [133:0] exp_q[$];
    int           out_cyc_q[$];
    logic [133:0] mon_e;

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        wait_cycles(2);
        i_rst = 1'b0;
        exp_q.delete();
        out_cyc_q.delete();
    endtask

    // ---------------- checks ----------------
    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_bits(input string name, input logic [133:0] got, input logic [133:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge i_clk) begin
        if (o_data_valid === 1'b1) begin
            out_cyc_q.push_back(cyc);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat got=%h expected=none", o_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_data !== mon_e) begin
                    n_fail++;
                    $display("FAIL out_beat got=%h expected=%h", o_data, mon_e);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_meta(input logic [127:0] m, output int c);
        i_meta_valid = 1'b1;
        i_meta       = m;
        c            = cyc;
        wait_cycles(1);
        i_meta_valid = 1'b0;
    endtask

    // Drives an n-beat packet with 'gap' idle cycles after each beat and
    // pushes the beats the paired meta m should produce.
    task automatic send_pkt(input int n, input int gap, input logic [127:0] m, output int head_c);
        head_c = 0;
        for (int i = 0; i < n; i++) begin
            logic [1:0]   tag;
            logic [133:0] b, e;
            tag = (n == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == n-1) ? 2'b10 : 2'b00;
            b = {tag, 4'($urandom_range(1, 15)), $urandom(), $urandom(), $urandom(), $urandom()};
            e = b;
            if (i == 0 && m[127]) begin
                e[127:80] = m[95:48];
                e[79:32]  = m[47:0];
            end
            if (!m[126]) exp_q.push_back(e);
            i_pkt_valid = 1'b1;
            i_pkt       = b;
            if (i == 0) head_c = cyc;
            wait_cycles(1);
            i_pkt_valid = 1'b0;
            wait_cycles(gap);
        end
    endtask

    function automatic logic [127:0] mk_meta(input logic rw, input logic drop,
                                             input logic [47:0] dst, input logic [47:0] src);
        return {rw, drop, 30'd0, dst, src};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst_before;
        logic [127:0] meta;
        int           nbeats;
        int           exp_pkt;
        int           exp_drop;
    } vec_t;

    vec_t tbl[6];
    logic [127:0] mq[17];
    int mc, hc;

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, mk_meta(1'b1, 1'b0, 48'h0A0B0C0D0E0F, 48'h112233445566), 4, 1, 0};
        tbl[1] = '{1'b1, mk_meta(1'b0, 1'b0, 48'hFFFFFFFFFFFF, 48'h123456789ABC), 3, 1, 0};
        tbl[2] = '{1'b0, mk_meta(1'b1, 1'b1, 48'hDEADBEEF0001, 48'hCAFEF00D0002), 5, 1, 1};
        tbl[3] = '{1'b0, mk_meta(1'b0, 1'b0, 48'h0, 48'h0), 1, 2, 1};
        tbl[4] = '{1'b0, mk_meta(1'b1, 1'b0, 48'h665544332211, 48'hA5A5A5A5A5A5), 1, 3, 1};
        tbl[5] = '{1'b0, mk_meta(1'b0, 1'b1, 48'h0, 48'h0), 1, 3, 2};

        i_rst = 1'b0; i_pkt_valid = 1'b0; i_pkt = '0; i_meta_valid = 1'b0; i_meta = '0;
        wait_cycles(1);
        do_reset();
        check_int("rst_valid", int'(o_data_valid), 0);
        check_bits("rst_data", o_data, '0);
        check_int("rst_pkt_cnt", int'(o_pkt_cnt), 0);
        check_int("rst_drop_cnt", int'(o_drop_cnt), 0);
        check_int("rst_ovf", int'(o_err_ovf), 0);

        // Rewrite, passthrough, drop, single-beat cases
        for (int v = 0; v < 6; v++) begin
            if (tbl[v].rst_before) do_reset();
            out_cyc_q.delete();
            send_meta(tbl[v].meta, mc);
            send_pkt(tbl[v].nbeats, 0, tbl[v].meta, hc);
            wait_cycles(10);
            check_int("vec_beats", out_cyc_q.size(), tbl[v].meta[126] ? 0 : tbl[v].nbeats);
            if (!tbl[v].meta[126]) check_int("vec_latency", out_cyc_q[0], hc + 3);
            check_int("vec_drain", exp_q.size(), 0);
            check_int("vec_pkt_cnt", int'(o_pkt_cnt), tbl[v].exp_pkt);
            check_int("vec_drop_cnt", int'(o_drop_cnt), tbl[v].exp_drop);
        end

        // Meta arriving 20 cycles after its packet
        out_cyc_q.delete();
        mq[0] = mk_meta(1'b1, 1'b0, 48'h010203040506, 48'h0708090A0B0C);
        send_pkt(6, 0, mq[0], hc);
        wait_cycles(hc + 20 - cyc);
        check_int("late_no_early_out", out_cyc_q.size(), 0);
        send_meta(mq[0], mc);
        wait_cycles(12);
        check_int("late_beats", out_cyc_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check_int("late_contig", out_cyc_q[i], mc + 3 + i);
        check_int("late_pkt_cnt", int'(o_pkt_cnt), 4);

        // Input gaps: bubbles in BODY
        out_cyc_q.delete();
        mq[0] = mk_meta(1'b0, 1'b0, 48'h0, 48'h0);
        send_meta(mq[0], mc);
        send_pkt(4, 2, mq[0], hc);
        wait_cycles(8);
        check_int("gap_beats", out_cyc_q.size(), 4);
        check_int("gap_out0", out_cyc_q[0], hc + 3);
        for (int i = 1; i < 4; i++)
            check_int("gap_outn", out_cyc_q[i], hc + 3*i + 2);
        check_int("gap_drain", exp_q.size(), 0);
        check_int("gap_pkt_cnt", int'(o_pkt_cnt), 5);

        // Meta FIFO overflow
        do_reset();
        for (int i = 0; i < 17; i++) begin
            mq[i] = mk_meta(1'b1, 1'b0, 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}));
            send_meta(mq[i], mc);
            if (i == 15) check_int("ovf_before", int'(o_err_ovf), 0);
        end
        check_int("ovf_set", int'(o_err_ovf), 1);
        for (int i = 0; i < 16; i++) send_pkt(2, 0, mq[i], hc);
        wait_cycles(40);
        check_int("ovf_beats", out_cyc_q.size(), 32);
        check_int("ovf_drain", exp_q.size(), 0);
        check_int("ovf_pkt_cnt", int'(o_pkt_cnt), 16);
        check_int("ovf_sticky", int'(o_err_ovf), 1);

        // Reset during beat 2 of an 8-beat packet
        do_reset();
        send_meta(mk_meta(1'b0, 1'b0, 48'h0, 48'h0), mc);
        for (int i = 0; i < 3; i++) begin
            i_pkt_valid = 1'b1;
            i_pkt       = {(i == 0) ? 2'b01 : 2'b00, 4'hF, 128'($urandom())};
            i_rst       = (i == 2);
            wait_cycles(1);
        end
        i_pkt_valid = 1'b0;
        i_rst       = 1'b0;
        check_int("midrst_valid", int'(o_data_valid), 0);
        check_bits("midrst_data", o_data, '0);
        check_int("midrst_pkt_cnt", int'(o_pkt_cnt), 0);
        check_int("midrst_drop_cnt", int'(o_drop_cnt), 0);
        check_int("midrst_ovf", int'(o_err_ovf), 0);
        wait_cycles(10);
        check_int("midrst_no_stale", out_cyc_q.size(), 0);
        mq[0] = mk_meta(1'b1, 1'b0, 48'hAABBCCDDEEFF, 48'h001122334455);
        send_meta(mq[0], mc);
        send_pkt(2, 0, mq[0], hc);
        wait_cycles(8);
        check_int("midrst_beats", out_cyc_q.size(), 2);
        check_int("midrst_drain", exp_q.size(), 0);
        check_int("midrst_pkt_cnt_after", int'(o_pkt_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_meta_merge.md
Name: pkt_meta_merge

Overview:
- Downstream neighbour of the parser/deparser stage in the hybrid packet pipeline.
- Buffers incoming 134b packet beats and the per-packet 128b meta produced by the parser/deparser.
- Pairs the i-th meta with the i-th packet, in order, and applies the meta action to the head beat: rewrite the MACs, pass the packet through, or drop it.
- Emits the result as a 134b beat stream, with status counters for the top level.

Parameters:
- PKT_AW, 9, log2 depth of packet-beat FIFO (512 x 134b).
- META_AW, 4, log2 depth of meta FIFO (16 x 128b).
- CNT_W, 32, width of statistics counters.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_pkt_valid  in  1  beat strobe.
- i_pkt  in  134  beat.
  - [133:132] head tag: 01 head, 10 tail, 00 middle, 11 single-beat.
  - [131:128] valid nibble.
  - [127:0] data.
- i_meta_valid  in  1  meta strobe, one per packet.
- i_meta  in  128  meta.
  - [127] rewrite_en.
  - [126] drop.
  - [95:48] new dst MAC.
  - [47:0] new src MAC.
- o_data_valid  out  1  output beat strobe.
- o_data  out  134  output beat.
- o_pkt_cnt  out  CNT_W  packets emitted (tail beats sent).
- o_drop_cnt  out  CNT_W  packets discarded by meta drop.
- o_err_ovf  out  1  sticky: a write hit a full FIFO.

Behaviour:
- Reset (i_rst high at a clock edge):
  - Both FIFOs flushed; FSM goes to IDLE.
  - o_data_valid, o_data, counters and o_err_ovf read 0 after that edge.
  - Reset mid-packet discards the partial packet and any queued meta. No stale beat appears after reset.
- FIFO writes are unconditional on strobe when not full.
- Write into a full FIFO:
  - The beat or meta is discarded and o_err_ovf is set.
  - o_err_ovf is cleared only by reset.
  - A simultaneous read and write on a full FIFO is not a full-write; the write is accepted.
- Meta may arrive before, during, or after its packet. Pairing is strictly FIFO order.
- FSM states: IDLE, HEAD, BODY, DROP.
- IDLE:
  - Go to HEAD when meta FIFO is non-empty AND packet FIFO is non-empty.
  - The meta entry is popped into a registered meta_r in the same cycle.
- HEAD:
  - Pops one beat.
  - If meta_r.drop = 1: the beat is not emitted. Go to DROP, or to IDLE if the beat tag is 10 or 11. o_drop_cnt increments on the tail.
  - If meta_r.drop = 0 and rewrite_en = 1: output data[127:80] = meta_r[95:48] and data[79:32] = meta_r[47:0]. Tag, valid nibble and data[31:0] are unchanged.
  - If meta_r.drop = 0 and rewrite_en = 0: the beat passes unchanged.
  - drop has priority over rewrite_en.
  - Next state is BODY, or IDLE if the tag is 10 or 11.
- BODY:
  - Pops and emits one beat per cycle while the packet FIFO is non-empty.
  - When the FIFO is empty, o_data_valid is 0 and the FSM holds (bubble); no underflow read is issued.
  - Go to IDLE after the tail beat; o_pkt_cnt increments on that cycle.
- DROP: same as BODY but beats are not emitted. Return to IDLE after the tail.
- Back-to-back packets: IDLE costs one cycle between packets.
- Latency: with meta already queued, a head beat written at cycle N appears on o_data at N+3.
  - N+1: FIFO non-empty visible, IDLE pops meta.
  - N+2: HEAD reads the beat.
  - N+3: registered output.
- Output registers: o_data_valid and o_data are registered. o_data holds its last value when not valid.
- Counters wrap modulo 2^CNT_W silently.
- Malformed input (head tag while in BODY) is not corrected. It is treated as a middle beat; the packet ends only at 10 or 11.

Test Plan:
1. Rewrite:
   - Stimulus: meta rewrite_en=1, dst=0x0A0B0C0D0E0F, src=0x112233445566, then a 4-beat packet.
   - Required: 4 beats out, in order. Beat0 data[127:80]=0x0A0B0C0D0E0F and data[79:32]=0x112233445566; all other bits match input. o_pkt_cnt=1. First output exactly 3 cycles after the head write.
2. Passthrough and drop:
   - Stimulus: meta rewrite_en=0 with packet A (3 beats); meta drop=1, rewrite_en=1 with packet B (5 beats); meta rewrite_en=0 with packet C (single beat, tag 11).
   - Required: A and C bit-exact, B absent. o_pkt_cnt=2, o_drop_cnt=1.
3. Meta late:
   - Stimulus: 6-beat packet written first, meta written 20 cycles later.
   - Required: no output before meta. Output is then 6 contiguous beats starting meta_write+3.
4. Underflow bubble:
   - Stimulus: meta queued; packet beats written with 2-cycle gaps.
   - Required: o_data_valid pulses track the input gaps. No duplicate or garbage beats; tail handled correctly.
5. Overflow:
   - Stimulus: 17 metas with no packets.
   - Required: o_err_ovf=1 after the 17th write. Then 16 packets supplied yield 16 outputs paired with metas 1-16.
6. Reset mid-packet:
   - Stimulus: assert i_rst during beat 2 of an 8-beat packet, then send a fresh meta and 2-beat packet.
   - Required: o_data_valid=0 and counters=0 after reset. Only the fresh 2-beat packet is output, with o_pkt_cnt=1.
